// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM mode arbiter: FSM state encodings, switch bit
// positions, port-owner enum and switch decode helpers.
package bram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_DUMP = 3'd5
  } arb_state_t;

  localparam int SW_RX  = 0;
  localparam int SW_RUN = 1;
  localparam int SW_TX  = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IO   = 2'd1,
    OWN_PRO  = 2'd2
  } owner_t;

  // A legal mode request has exactly one switch set.
  function automatic logic sw_legal(input logic [2:0] sw);
    return $onehot(sw);
  endfunction

  // More than one switch set at once.
  function automatic logic sw_multi(input logic [2:0] sw);
    return (sw[0] & sw[1]) | (sw[0] & sw[2]) | (sw[1] & sw[2]);
  endfunction

endpackage

// File: rtl/bram_mode_arbiter_if.sv
// Bus bundle between the arbiter, its two clients (IO loader and processor)
// and the single BRAM port. The arbiter side uses the master modport.
interface bram_mode_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_we;
  logic [DATA_W-1:0] io_rdata;

  logic [ADDR_W-1:0] pro_addr;
  logic [DATA_W-1:0] pro_wdata;
  logic              pro_we;
  logic [DATA_W-1:0] pro_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  io_addr, io_wdata, io_we,
    input  pro_addr, pro_wdata, pro_we,
    input  mem_rdata,
    output io_rdata, pro_rdata,
    output mem_addr, mem_wdata, mem_we, mem_en
  );

  modport slave (
    output io_addr, io_wdata, io_we,
    output pro_addr, pro_wdata, pro_we,
    output mem_rdata,
    input  io_rdata, pro_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_en
  );
endinterface

// File: rtl/bram_port_mux.sv
// BRAM port mux: combinational address/data/write-enable selection from the
// current owner, plus one-cycle registered read-return routing. The client
// that does not own the returned read keeps its last rdata value.
module bram_port_mux
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk_100,
  input  logic              rst,
  input  owner_t            owner,
  input  logic              io_we_ok,
  input  logic              pro_we_ok,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] pro_addr,
  input  logic [DATA_W-1:0] pro_wdata,
  input  logic              pro_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  output logic [DATA_W-1:0] io_rdata,
  output logic [DATA_W-1:0] pro_rdata
);

  owner_t            rd_owner_q;
  logic [DATA_W-1:0] io_hold_q;
  logic [DATA_W-1:0] pro_hold_q;

  // Drive the BRAM port from whichever client owns it; nothing when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_en    = 1'b0;
    case (owner)
      OWN_IO: begin
        mem_en    = 1'b1;
        mem_addr  = io_addr;
        mem_wdata = io_wdata;
        mem_we    = io_we & io_we_ok;
      end
      OWN_PRO: begin
        mem_en    = 1'b1;
        mem_addr  = pro_addr;
        mem_wdata = pro_wdata;
        mem_we    = pro_we & pro_we_ok;
      end
      default: ;
    endcase
  end

  // Track who issued last cycle's read and latch returned data per client.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      rd_owner_q <= OWN_NONE;
      io_hold_q  <= '0;
      pro_hold_q <= '0;
    end else begin
      rd_owner_q <= owner;
      if (rd_owner_q == OWN_IO)  io_hold_q  <= mem_rdata;
      if (rd_owner_q == OWN_PRO) pro_hold_q <= mem_rdata;
    end
  end

  // The BRAM has one cycle of latency, so fresh data is passed straight
  // through in the cycle it arrives; otherwise the held value is shown.
  assign io_rdata  = (rd_owner_q == OWN_IO)  ? mem_rdata : io_hold_q;
  assign pro_rdata = (rd_owner_q == OWN_PRO) ? mem_rdata : pro_hold_q;

endmodule

// File: rtl/bram_mode_arbiter.sv
// BRAM mode arbiter: grants the shared data BRAM to the UART IO client or the
// processor based on the mode switches, and sequences the processor enable.
// Optional build macro RUN_WATCHDOG_EN adds a run-length watchdog that forces
// DONE and raises a sticky timeout flag.
//
// state | meaning
// IDLE  | no owner, BRAM port disabled; waits for a single legal switch
// LOAD  | IO client owns the BRAM, writes allowed
// ARM   | processor owns the BRAM, start delay running, pro_en low
// RUN   | processor enabled, run_cycles counting
// DONE  | processor halted, run_cycles held until run switch drops
// DUMP  | IO client owns the BRAM, writes blocked
module bram_mode_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int START_DELAY = 2,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic [2:0]       ctrl_sw,
  bram_mode_arbiter_if.master bus,
  input  logic             pro_finished,
  output logic             pro_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] run_cycles,
  output logic             led_pro,
  output logic             mode_err,
  output logic             timeout
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [DLY_W-1:0] dly_q;
  logic             sw_ok;
  logic             wdog_hit;
  logic             arm_entry;
  owner_t           owner;

  assign sw_ok     = sw_legal(ctrl_sw);
  assign arm_entry = (state_q == ST_IDLE) && (state_d == ST_ARM);

`ifdef RUN_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WD_W-1:0] wdog_q;

  assign wdog_hit = (state_q == ST_RUN) && (wdog_q == '0);

  // Watchdog down-counter: reloaded outside RUN, terminal count ends the run.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      wdog_q <= WD_W'(WDOG_CYCLES - 1);
    end else if (state_q != ST_RUN) begin
      wdog_q <= WD_W'(WDOG_CYCLES - 1);
    end else if (wdog_q != '0) begin
      wdog_q <= wdog_q - 1'b1;
    end
  end

  // Sticky timeout, cleared only when a new run is armed.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (arm_entry) begin
      timeout <= 1'b0;
    end else if (wdog_hit && ctrl_sw[SW_RUN]) begin
      timeout <= 1'b1;
    end
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign timeout     = 1'b0;
  assign unused_wdog = |32'(WDOG_CYCLES);
`endif

  // Next-state decode; any mode change is forced through IDLE so an
  // in-flight read drains before the port changes hands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_ok) begin
          if (ctrl_sw[SW_RX])       state_d = ST_LOAD;
          else if (ctrl_sw[SW_RUN]) state_d = ST_ARM;
          else                      state_d = ST_DUMP;
        end
      end
      ST_LOAD: if (!sw_ok || !ctrl_sw[SW_RX]) state_d = ST_IDLE;
      ST_DUMP: if (!sw_ok || !ctrl_sw[SW_TX]) state_d = ST_IDLE;
      ST_ARM: begin
        if (!ctrl_sw[SW_RUN])  state_d = ST_IDLE;
        else if (dly_q == '0)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!ctrl_sw[SW_RUN])              state_d = ST_IDLE;
        else if (pro_finished || wdog_hit) state_d = ST_DONE;
      end
      ST_DONE: if (!ctrl_sw[SW_RUN]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Start-delay down-counter, loaded outside ARM so each ARM visit starts fresh.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      dly_q <= DLY_W'(START_DELAY - 1);
    end else if (state_q != ST_ARM) begin
      dly_q <= DLY_W'(START_DELAY - 1);
    end else if (dly_q != '0) begin
      dly_q <= dly_q - 1'b1;
    end
  end

  // Saturating count of enabled cycles, cleared when a new run is armed.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (arm_entry) begin
      run_cycles <= '0;
    end else if (pro_en && (run_cycles != '1)) begin
      run_cycles <= run_cycles + 1'b1;
    end
  end

  // Registered flag for conflicting switch settings.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) mode_err <= 1'b0;
    else     mode_err <= sw_multi(ctrl_sw);
  end

  // Owner decode from the current state.
  always_comb begin
    owner = OWN_NONE;
    case (state_q)
      ST_LOAD, ST_DUMP:        owner = OWN_IO;
      ST_ARM, ST_RUN, ST_DONE: owner = OWN_PRO;
      default:                 owner = OWN_NONE;
    endcase
  end

  // pro_en decodes straight from the state register, so an async reset
  // drops it without waiting for a clock edge.
  assign pro_en  = (state_q == ST_RUN);
  assign led_pro = (state_q == ST_RUN);
  assign state   = state_q;

  bram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .clk_100   (clk_100),
    .rst       (rst),
    .owner     (owner),
    .io_we_ok  (state_q == ST_LOAD),
    .pro_we_ok (pro_en),
    .io_addr   (bus.io_addr),
    .io_wdata  (bus.io_wdata),
    .io_we     (bus.io_we),
    .pro_addr  (bus.pro_addr),
    .pro_wdata (bus.pro_wdata),
    .pro_we    (bus.pro_we),
    .mem_rdata (bus.mem_rdata),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we),
    .mem_en    (bus.mem_en),
    .io_rdata  (bus.io_rdata),
    .pro_rdata (bus.pro_rdata)
  );

endmodule
